pipelined_rca: RTL and testbench
================================

# pipelined_rca

Parameterised, pipelined ripple-carry adder: successor to the combinational parameterised RCA. The N-bit add is split into SEG-bit ripple slices, with one register stage per slice. Each slice's carry is registered into the next stage, so throughput is one add per clock at any N. A valid/ready handshake on both sides lets the block sit directly in streaming datapaths, and the self-checking benches drive it the same way.

## Interface
- N, 16, operand/sum width; must be a multiple of SEG.
- SEG, 4, slice width per pipeline stage; STAGES = N/SEG (1..N).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  N  operand A (unsigned, or two's complement for ovf).
- b  input  N  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- s  output  N  sum, {cout,s} = a+b+cin.
- cout  output  1  carry out of bit N-1.
- ovf  output  1  signed overflow; present only with PIPE_RCA_OVF_EN.

## Operation
- Stage k (0..STAGES-1) adds slice k of A/B, a[k*SEG +: SEG] and b[k*SEG +: SEG], plus the carry registered by stage k-1. Stage 0 uses cin.
- Operand skew: slice k travels through k delay registers before it is added.
- Sum deskew: each slice sum travels through STAGES-1-k registers after it is added.
- As a result, all N sum bits, cout and ovf of one beat leave together.
- Each stage carries a valid bit. The out_valid signal is the valid bit of the last stage.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, a combinational path from out_ready.
- When adv=1, every stage register (data, carry, valid) loads from its predecessor. Stage 0 loads {a,b,cin,in_valid}.
- When adv=0, all registers hold. s, cout and ovf remain stable while out_valid=1 && out_ready=0.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages and are not collapsed.
- Arithmetic is modulo 2^N on s. cout is the exact carry out of bit N-1. No saturation.
- Results emerge strictly in input order. No beat is lost or duplicated across stalls.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits, out_valid, s, cout and ovf go to 0 immediately. in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight beats. After release, the first output appears only for beats accepted after reset.
- Latency: a beat accepted at edge t (in_valid && in_ready) is presented with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles after acceptance, assuming no stalls. Each stalled cycle adds one.
- STAGES=1 (SEG=N): single register stage, latency 1 cycle, no skew or deskew registers.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous output handshake and input acceptance in the same cycle is allowed and required for full throughput.
- in_valid may drop without a handshake. a, b and cin are sampled only on acceptance.

## Configuration
- PIPE_RCA_OVF_EN defined:
  - The ovf port exists. ovf = carry into bit N-1 XOR carry out of bit N-1, for the same beat as s.
  - ovf is deskewed and held with s, and resets to 0.
- PIPE_RCA_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset check: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid, s, cout = 0 at once. After release, no stale beat appears and in_ready=1.
- Carry chain: N=16, SEG=4, a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1. out_valid rises exactly 4 cycles after acceptance.
- Streaming: out_ready=1, 200 back-to-back random {a,b,cin} beats -> every result equals a+b+cin (N+1 bits), in order. A PASS/FAIL line is printed per beat, and there are 200 outputs in 200+STAGES-1 cycles.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> s/cout unchanged and in_ready=0. After release, the next beats follow with no gaps or duplicates.
- Overflow (PIPE_RCA_OVF_EN): a=16'h7FFF, b=16'h0001, cin=0 -> s=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h8000 -> s=0, cout=1, ovf=1.
- Degenerate config: N=8, SEG=8, a=8'hC8, b=8'h64, cin=1 -> s=8'h2D, cout=1, with latency 1 cycle.

Source files
------------

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: N-bit add split into N/SEG ripple slices, one register stage per slice.
// Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int STAGES = N / SEG;

    // Handshake: a beat moves on every edge where adv=1; the whole pipe stalls together otherwise.
    logic              adv;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    logic [N-1:0]      sum_d;

    assign adv       = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic           c_in;
        logic [SEG-1:0] sum_q [STAGES-k];

        if (k == 0) begin : g_direct
            assign op_a[SEG-1:0] = a[SEG-1:0];
            assign op_b[SEG-1:0] = b[SEG-1:0];
            assign c_in          = cin;
        end else begin : g_skew
            // Slice k of the operands waits k cycles so it meets the carry from slice k-1.
            logic [SEG-1:0] a_dly_q [k];
            logic [SEG-1:0] b_dly_q [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_dly_q[i] <= '0;
                        b_dly_q[i] <= '0;
                    end
                end else if (adv) begin
                    a_dly_q[0] <= a[k*SEG +: SEG];
                    b_dly_q[0] <= b[k*SEG +: SEG];
                    for (int i = 1; i < k; i++) begin
                        a_dly_q[i] <= a_dly_q[i-1];
                        b_dly_q[i] <= b_dly_q[i-1];
                    end
                end
            end

            assign op_a[k*SEG +: SEG] = a_dly_q[k-1];
            assign op_b[k*SEG +: SEG] = b_dly_q[k-1];
            assign c_in               = carry_q[k-1];
        end

        assign {carry_d[k], sum_d[k*SEG +: SEG]} = {1'b0, op_a[k*SEG +: SEG]}
                                                 + {1'b0, op_b[k*SEG +: SEG]}
                                                 + {{SEG{1'b0}}, c_in};

        // Early slices wait here so every slice of a beat reaches the output together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES - k; i++) begin
                    sum_q[i] <= '0;
                end
            end else if (adv) begin
                sum_q[0] <= sum_d[k*SEG +: SEG];
                for (int i = 1; i < STAGES - k; i++) begin
                    sum_q[i] <= sum_q[i-1];
                end
            end
        end

        assign s[k*SEG +: SEG] = sum_q[STAGES-k-1];
    end

`ifdef PIPE_RCA_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is recovered as a^b^sum at that bit.
    assign ovf_d = carry_d[STAGES-1] ^ (op_a[N-1] ^ op_b[N-1] ^ sum_d[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: 16/4 instance with scoreboard + 8/8 degenerate instance.
// Builds with or without PIPE_RCA_OVF_EN.
module tb_pipelined_rca;

    localparam int N      = 16;
    localparam int SEG    = 4;
    localparam int STAGES = N / SEG;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf_w;

    logic         d8_in_valid;
    logic         d8_in_ready;
    logic [7:0]   d8_a;
    logic [7:0]   d8_b;
    logic         d8_cin;
    logic         d8_out_valid;
    logic         d8_out_ready;
    logic [7:0]   d8_s;
    logic         d8_cout;
    logic         d8_ovf_w;

`ifdef PIPE_RCA_OVF_EN
    logic ovf;
    logic d8_ovf;
    assign ovf_w    = ovf;
    assign d8_ovf_w = d8_ovf;
`else
    assign ovf_w    = 1'b0;
    assign d8_ovf_w = 1'b0;
`endif

    pipelined_rca #(.N(N), .SEG(SEG)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef PIPE_RCA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_rca #(.N(8), .SEG(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .a         (d8_a),
        .b         (d8_b),
        .cin       (d8_cin),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .s         (d8_s),
        .cout      (d8_cout)
`ifdef PIPE_RCA_OVF_EN
        ,
        .ovf       (d8_ovf)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int             n_cmp = 0;
    int             n_err = 0;
    int             out_count = 0;
    logic [N+1:0]   exp_q[$];
    logic           prev_stall = 1'b0;
    logic [N:0]     prev_data = '0;
    logic           rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, s[63:0]} for width w.
    function automatic logic [65:0] model_w(input longint unsigned x, input longint unsigned y,
                                            input logic c, input int w);
        longint unsigned u;
        longint unsigned mask;
        longint          half;
        longint          sx;
        longint          sy;
        longint          t;
        logic [65:0]     r;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        u     = x + y + longint'(c);
        sx    = (x >= half) ? longint'(x) - 2 * half : longint'(x);
        sy    = (y >= half) ? longint'(y) - 2 * half : longint'(y);
        t     = sx + sy + longint'(c);
        r     = '0;
        r[63:0] = u & mask;
        r[64]   = ((u >> w) & 1) != 0;
`ifdef PIPE_RCA_OVF_EN
        r[65]   = (t >= half) || (t < -half);
`else
        r[65]   = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [N+1:0] model_main(input logic [N-1:0] x, input logic [N-1:0] y,
                                                input logic c);
        logic [65:0] r;
        r = model_w(longint'(x), longint'(y), c, N);
        return {r[65], r[64], r[N-1:0]};
    endfunction

    // ---------------- scoreboard: push on acceptance ----------------
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model_main(a, b, cin));
        end
    end

    // ---------------- scoreboard: monitor ----------------
    always @(negedge clk) begin
        logic [N+1:0] act;
        logic [N+1:0] exp_v;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            act = {ovf_w, cout, s};
            check("in_ready rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall out_valid held", 64'(out_valid), 64'd1);
                check("stall data held", 64'({cout, s}), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected output: got %0h with nothing expected at %0t", act, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("result", 64'(act), 64'(exp_v));
                    if (act === exp_v) begin
                        $display("PASS beat %0d: {ovf,cout,s}=%0h", out_count, act);
                    end
                end
                out_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = {cout, s};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc);
        logic acc;
        int   n;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic drive_random;
        drive_beat(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain queue empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (30000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: cycle budget expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        int          base;
        logic [65:0] r8;
        logic [65:0] prev8;
        logic        have_prev8;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;
        out_ready    = 1'b1;
        d8_in_valid  = 1'b0;
        d8_a         = '0;
        d8_b         = '0;
        d8_cin       = 1'b0;
        d8_out_ready = 1'b1;
        rand_done    = 1'b0;

        #2;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset s", 64'(s), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf_w), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset d8 out_valid", 64'(d8_out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // carry ripples through all four slices; measure latency
        drive_beat(16'hFFFF, 16'h0001, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("carry chain latency", 64'(lat), 64'(STAGES));
        drain();

        // signed overflow corners and extremes
        drive_beat(16'h7FFF, 16'h0001, 1'b0);
        drive_beat(16'h8000, 16'h8000, 1'b0);
        drive_beat(16'hFFFF, 16'hFFFF, 1'b1);
        drive_beat(16'h0000, 16'h0000, 1'b0);
        drive_beat(16'h7FFF, 16'h7FFF, 1'b1);
        drain();

        // back-to-back streaming, 200 beats
        base = out_count;
        for (int i = 0; i < 200; i++) begin
            drive_random();
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream outputs before last cycle", 64'(out_count - base), 64'd199);
        @(posedge clk);
        #1;
        check("stream outputs total", 64'(out_count - base), 64'd200);
        drain();

        // backpressure: fill the pipe, then hold out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive_random();
        end
        in_valid = 1'b1;
        a        = N'($urandom);
        b        = N'($urandom);
        cin      = 1'($urandom_range(0, 1));
        repeat (3) begin
            @(negedge clk);
            check("stall in_ready", 64'(in_ready), 64'd0);
            check("stall out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
        end
        drain();

        // random bubbles on input, random backpressure on output
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    drive_random();
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with beats in flight and one presented
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive_random();
        end
        @(negedge clk);
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset s", 64'(s), 64'd0);
        check("async reset cout", 64'(cout), 64'd0);
        check("async reset ovf", 64'(ovf_w), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        base = out_count;
        repeat (8) @(posedge clk);
        #1;
        check("no stale beats after reset", 64'(out_count - base), 64'd0);
        check("idle out_valid after reset", 64'(out_valid), 64'd0);
        check("in_ready after reset", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive_random();
        end
        drain();

        // degenerate single-stage instance
        @(posedge clk);
        #1;
        d8_in_valid = 1'b1;
        d8_a        = 8'hC8;
        d8_b        = 8'h64;
        d8_cin      = 1'b1;
        @(negedge clk);
        check("d8 in_ready", 64'(d8_in_ready), 64'd1);
        check("d8 idle out_valid", 64'(d8_out_valid), 64'd0);
        @(posedge clk);
        #1;
        d8_in_valid = 1'b0;
        @(negedge clk);
        check("d8 latency out_valid", 64'(d8_out_valid), 64'd1);
        check("d8 s", 64'(d8_s), 64'h2D);
        check("d8 cout", 64'(d8_cout), 64'd1);
        check("d8 ovf", 64'(d8_ovf_w), 64'd0);
        have_prev8 = 1'b0;
        prev8      = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            d8_in_valid = 1'b1;
            d8_a        = 8'($urandom);
            d8_b        = 8'($urandom);
            d8_cin      = 1'($urandom_range(0, 1));
            r8          = model_w(longint'(d8_a), longint'(d8_b), d8_cin, 8);
            @(negedge clk);
            if (have_prev8) begin
                check("d8 stream valid", 64'(d8_out_valid), 64'd1);
                check("d8 stream result", 64'({d8_ovf_w, d8_cout, d8_s}),
                      64'({prev8[65], prev8[64], prev8[7:0]}));
            end
            prev8      = r8;
            have_prev8 = 1'b1;
        end
        @(posedge clk);
        #1;
        d8_in_valid = 1'b0;
        @(negedge clk);
        check("d8 last valid", 64'(d8_out_valid), 64'd1);
        check("d8 last result", 64'({d8_ovf_w, d8_cout, d8_s}),
              64'({prev8[65], prev8[64], prev8[7:0]}));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("d8 drained", 64'(d8_out_valid), 64'd0);

        check("final queue empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
